// File: rtl/frame_stream_source.sv
// frame_stream_source: raster-order pixel source for the dstream pipeline.
// Reads one WIDTH x HEIGHT frame from a synchronous-read frame memory and
// sends it out on a valid/ready stream, honouring backpressure and sustaining
// one pixel per clock while y_ready stays high.
//
// Optional build macro: FRAME_SRC_LOOP_EN
//   defined   -> continuous streaming; the address wraps to 0 and the source
//                stays in READ, frame_done pulses per frame, busy holds until reset
//   undefined -> one frame per accepted start

module frame_stream_source #(
    parameter int unsigned W      = 30,
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rdata,
    output logic [W-1:0]  y_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned NPIX     = WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;

    // Two-entry output buffer: y_data is the head, fifo_tail the second slot.
    logic [1:0]    fifo_count;
    logic [1:0]    fifo_count_next;
    logic [W-1:0]  fifo_tail;

    // A memory read was issued last edge; its data is on mem_rdata now.
    logic          inflight;

    // Output handshake counter, used to spot the last pixel of a frame.
    logic [AW-1:0] pix_cnt;

    logic          pop;
    logic          push;
    logic          start_accept;
    logic          last_pix;
    logic          rd_last;
    logic [2:0]    occupancy;

    // Handshake, push and read-issue qualifiers.
    always_comb begin
        pop          = y_valid & y_ready;
        push         = inflight;
        start_accept = (state == S_IDLE) & start;
        last_pix     = pop & (pix_cnt == LAST_ADDR);
        occupancy    = 3'(fifo_count) + 3'(inflight);
        // Space check counts a same-cycle pop so the buffer never overflows
        // yet the stream sustains one pixel per clock.
        mem_rd_en    = (state == S_READ) & (occupancy < (3'd2 + 3'(pop)));
        rd_last      = mem_rd_en & (mem_addr == LAST_ADDR);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
`ifdef FRAME_SRC_LOOP_EN
                state_next = S_READ;
`else
                if (rd_last) begin
                    state_next = S_DRAIN;
                end
`endif
            end
            S_DRAIN: begin
                if (last_pix) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read address: restarts at 0 per frame and wraps after the last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
        end else if (start_accept) begin
            mem_addr <= '0;
        end else if (mem_rd_en) begin
            if (rd_last) begin
                mem_addr <= '0;
            end else begin
                mem_addr <= mem_addr + AW'(1);
            end
        end
    end

    // In-flight flag: data for a read issued at this edge returns next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
        end
    end

    // Buffer occupancy after this edge.
    always_comb begin
        fifo_count_next = fifo_count;
        if (push && !pop) begin
            fifo_count_next = fifo_count + 2'd1;
        end else if (pop && !push) begin
            fifo_count_next = fifo_count - 2'd1;
        end
    end

    // Output buffer storage; simultaneous push and pop keeps order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_count <= 2'd0;
            y_valid    <= 1'b0;
            y_data     <= '0;
            fifo_tail  <= '0;
        end else begin
            fifo_count <= fifo_count_next;
            y_valid    <= (fifo_count_next != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        y_data <= mem_rdata;
                    end else begin
                        fifo_tail <= mem_rdata;
                    end
                end
                2'b01: begin
                    y_data <= fifo_tail;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        y_data <= mem_rdata;
                    end else begin
                        y_data    <= fifo_tail;
                        fifo_tail <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output pixel counter, cleared at the start of each frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
        end else if (start_accept) begin
            pix_cnt <= '0;
        end else if (pop) begin
            if (pix_cnt == LAST_ADDR) begin
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt + AW'(1);
            end
        end
    end

    // busy spans start acceptance to the final handshake; frame_done pulses once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_pix;
            if (start_accept) begin
                busy <= 1'b1;
            end
`ifndef FRAME_SRC_LOOP_EN
            else if (last_pix) begin
                busy <= 1'b0;
            end
`endif
        end
    end

endmodule
